forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit.sv | 100 ++++++++++
 tb/tb_forward_hazard_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// Operand forwarding select and load-use stall detection for the EXE stage.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module forward_hazard_unit #(
    parameter int ADDR_W  = 4,
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      exe_valid,
    input  logic                      exe_wb_en,
    input  logic                      exe_mem_read,
    input  logic [ADDR_W-1:0]         exe_dest,
    input  logic [NUM_SRC*ADDR_W-1:0] exe_src,
    input  logic [NUM_SRC-1:0]        exe_src_used,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      freeze,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      hazard_stall
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               fwd_cnt
`endif
);

    logic [DEPTH:1]    slot_valid;
    logic [DEPTH:1]    slot_wb_en;
    logic [ADDR_W-1:0] slot_dest [1:DEPTH];
    logic              id_hit;

    // Shift the EXE producer down the tracked slots unless the pipe is frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                slot_valid[k] <= 1'b0;
                slot_wb_en[k] <= 1'b0;
                slot_dest[k]  <= '0;
            end
        end else if (!freeze) begin
            slot_valid[1] <= exe_valid;
            slot_wb_en[1] <= exe_wb_en;
            slot_dest[1]  <= exe_dest;
            for (int k = 2; k <= DEPTH; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_wb_en[k] <= slot_wb_en[k-1];
                slot_dest[k]  <= slot_dest[k-1];
            end
        end
    end

    // Per operand pick the youngest matching producer; scanning oldest first
    // lets the younger slot overwrite the choice
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (exe_valid && exe_src_used[i] &&
                    slot_valid[k] && slot_wb_en[k] &&
                    (slot_dest[k] == exe_src[i*ADDR_W +: ADDR_W])) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    // Load in EXE feeding any read operand in ID stalls, unless flushed
    always_comb begin
        id_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] &&
                (id_src[i*ADDR_W +: ADDR_W] == exe_dest)) begin
                id_hit = 1'b1;
            end
        end
        hazard_stall = exe_valid && exe_wb_en && exe_mem_read &&
                       !flush && id_hit;
    end

`ifdef FWD_PERF_CNT_EN
    // Saturating event counters; they keep counting through a freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (hazard_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((|fwd_sel) && (fwd_cnt != 32'hFFFF_FFFF)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed self-checking bench for forward_hazard_unit (default parameters).
module tb_forward_hazard_unit;

    localparam int ADDR_W  = 4;
    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 2;
    localparam int SEL_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      exe_valid;
    logic                      exe_wb_en;
    logic                      exe_mem_read;
    logic [ADDR_W-1:0]         exe_dest;
    logic [NUM_SRC*ADDR_W-1:0] exe_src;
    logic [NUM_SRC-1:0]        exe_src_used;
    logic [NUM_SRC*ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      freeze;
    logic                      flush;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      hazard_stall;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]               stall_cnt;
    logic [31:0]               fwd_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    forward_hazard_unit #(
        .ADDR_W (ADDR_W),
        .NUM_SRC(NUM_SRC),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exe_valid   (exe_valid),
        .exe_wb_en   (exe_wb_en),
        .exe_mem_read(exe_mem_read),
        .exe_dest    (exe_dest),
        .exe_src     (exe_src),
        .exe_src_used(exe_src_used),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .freeze      (freeze),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .hazard_stall(hazard_stall)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        #1;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel(input int i);
        return 32'(fwd_sel[i*SEL_W +: SEL_W]);
    endfunction

    initial begin
        rst = 1'b1; exe_valid = 0; exe_wb_en = 0; exe_mem_read = 0;
        exe_dest = '0; exe_src = '0; exe_src_used = '0;
        id_src = '0; id_src_used = '0; freeze = 0; flush = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("reset_stall", 32'(hazard_stall), 32'd0);

        // Writer of r5, then reader one and two cycles later
        exe_valid = 1; exe_wb_en = 1; exe_dest = 4'd5;
        tick();
        exe_wb_en = 0; exe_dest = 4'd0;
        exe_src = {4'd0, 4'd0, 4'd5}; exe_src_used = 3'b001;
        #1;
        chk("r5_slot1", sel(0), 32'd1);
        tick();
        #1;
        chk("r5_slot2", sel(0), 32'd2);
        exe_src = {4'd0, 4'd0, 4'd5}; exe_src_used = 3'b011;
        #1;
        chk("no_wb_slot_nomatch", sel(1), 32'd0);
        exe_valid = 0;
        #1;
        chk("exe_bubble_nofwd", 32'(fwd_sel), 32'd0);

        // Bubble enters slot 1 and must not match
        exe_dest = 4'd5;
        tick();
        exe_valid = 1; exe_src_used = 3'b001;
        #1;
        chk("bubble_slot_nomatch", 32'(fwd_sel), 32'd0);

        // Two writers of r3: youngest wins, unused operand stays 0
        exe_valid = 1; exe_wb_en = 1; exe_dest = 4'd3; exe_src_used = '0;
        tick(); tick();
        exe_wb_en = 0; exe_dest = 4'd9;
        exe_src = {4'd3, 4'd3, 4'd3}; exe_src_used = 3'b011;
        #1;
        chk("youngest_wins", sel(1), 32'd1);
        chk("shared_slot_op0", sel(0), 32'd1);
        chk("unused_op2", sel(2), 32'd0);

        // Register 0 forwards normally
        exe_wb_en = 1; exe_dest = 4'd0; exe_src_used = '0;
        tick();
        exe_wb_en = 0; exe_dest = 4'd9;
        exe_src = {4'd0, 4'd0, 4'd0}; exe_src_used = 3'b100;
        #1;
        chk("r0_forwards", sel(2), 32'd1);

        // Load-use hazard and its suppressors
        exe_src_used = '0;
        exe_valid = 1; exe_wb_en = 1; exe_mem_read = 1; exe_dest = 4'd7;
        id_src = {4'd1, 4'd2, 4'd7}; id_src_used = 3'b001;
        #1;
        chk("load_use_stall", 32'(hazard_stall), 32'd1);
        flush = 1;
        #1;
        chk("flush_kills_stall", 32'(hazard_stall), 32'd0);
        flush = 0; id_src_used = 3'b110;
        #1;
        chk("unused_id_src", 32'(hazard_stall), 32'd0);
        id_src = {4'd7, 4'd2, 4'd1}; id_src_used = 3'b100;
        #1;
        chk("stall_op2", 32'(hazard_stall), 32'd1);
        exe_mem_read = 0;
        #1;
        chk("non_load_no_stall", 32'(hazard_stall), 32'd0);
        id_src_used = '0;

        // Freeze holds slot 1 = r4 for three cycles
        exe_dest = 4'd4;
        tick();
        exe_wb_en = 0; exe_dest = 4'd9; freeze = 1;
        exe_src = {4'd0, 4'd0, 4'd4}; exe_src_used = 3'b001;
        #1;
        chk("freeze_c0", sel(0), 32'd1);
        exe_wb_en = 1; exe_mem_read = 1; exe_dest = 4'd6;
        id_src = {4'd0, 4'd0, 4'd6}; id_src_used = 3'b001;
        #1;
        chk("freeze_keeps_stall", 32'(hazard_stall), 32'd1);
        exe_wb_en = 0; exe_mem_read = 0; exe_dest = 4'd9; id_src_used = '0;
        tick();
        chk("freeze_c1", sel(0), 32'd1);
        tick();
        chk("freeze_c2", sel(0), 32'd1);
        tick();
        chk("freeze_c3", sel(0), 32'd1);
        freeze = 0;
        tick();
        chk("after_freeze", sel(0), 32'd2);

        // Reset with freeze asserted clears populated slots
        exe_wb_en = 1; exe_dest = 4'd4;
        tick();
        chk("pre_reset_fwd", sel(0), 32'd1);
        rst = 1; freeze = 1;
        tick();
        rst = 0; freeze = 0;
        #1;
        chk("reset_freeze_fwd", 32'(fwd_sel), 32'd0);
`ifdef FWD_PERF_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_fwd_cnt", fwd_cnt, 32'd0);

        // Five stall cycles with no forwarding
        exe_src_used = '0;
        exe_valid = 1; exe_wb_en = 1; exe_mem_read = 1; exe_dest = 4'd7;
        id_src = {4'd0, 4'd0, 4'd7}; id_src_used = 3'b001;
        for (int c = 0; c < 5; c++) tick();
        // Three forwarding cycles with no stall
        exe_mem_read = 0; id_src_used = '0;
        exe_src = {4'd0, 4'd0, 4'd7}; exe_src_used = 3'b001;
        for (int c = 0; c < 3; c++) tick();
        exe_src_used = '0;
        #1;
        chk("stall_cnt_5", stall_cnt, 32'd5);
        chk("fwd_cnt_3", fwd_cnt, 32'd3);

        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        exe_mem_read = 1; id_src_used = 3'b001;
        tick();
        chk("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
        exe_mem_read = 0; id_src_used = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
